// File: rtl/serdesphy_tx_serial_engine_if.sv
// Parallel write bus into the TX serial engine word FIFO.
interface serdesphy_tx_serial_engine_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [LvlW-1:0]   fifo_level;

  // Producer side: drives words, observes backpressure and occupancy.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  fifo_level
  );

  // Engine side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output fifo_level
  );
endinterface

// File: rtl/serdesphy_tx_serial_engine.sv
// TX serial engine: word FIFO or PRBS7 source, preamble framing, Manchester/NRZ line
// encoding, one line symbol per bit_en strobe. Single 240 MHz clock domain.
module serdesphy_tx_serial_engine #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned ERR_LIMIT    = 7
) (
  input  logic                           clk_240m_tx,
  input  logic                           rst_n_240m_tx,
  input  logic                           tx_en,
  input  logic                           bit_en,
  input  logic                           tx_idle,
  input  logic                           tx_data_sel,
  input  logic                           mode_manchester,
  input  logic                           clr_sticky,
  serdesphy_tx_serial_engine_if.slave    wr,
  output logic                           tx_serial_data,
  output logic                           tx_serial_valid,
  output logic                           tx_idle_pattern,
  output logic                           tx_active,
  output logic                           tx_overflow,
  output logic                           tx_underflow,
  output logic                           tx_error
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned IdxW = $clog2(DATA_W);
  localparam int unsigned PreW = $clog2(PREAMBLE_LEN + 1);

  localparam logic [LvlW-1:0] FifoFull = LvlW'(FIFO_DEPTH);
  localparam logic [IdxW-1:0] IdxTop   = IdxW'(DATA_W - 1);
  localparam logic [PreW-1:0] PreLast  = PreW'(PREAMBLE_LEN);
  localparam logic [6:0]      LfsrSeed = 7'h7F;

  typedef enum logic [2:0] {
    StDisabled,
    StIdle,
    StPreamble,
    StActive,
    StError
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic [6:0]        lfsr_q;
  logic [7:0]        err_cnt_q;
  logic [DATA_W-1:0] word_q;
  logic [IdxW-1:0]   bit_idx_q;
  logic              half_q;
  logic              mode_q;
  logic [PreW-1:0]   pre_cnt_q;

  logic              in_ready_w, push, pop, fifo_empty;
  logic              at_last_sym, word_end, end_to_idle, underflow_evt, load, go_error;
  logic [8:0]        err_cnt_inc;
  logic [IdxW-1:0]   idx_m1;
  logic [6:0]        prbs_lfsr;
  logic [DATA_W-1:0] prbs_word, next_word;

  // Acceptance is based on the registered level only, so a full FIFO rejects a write
  // even when a pop happens in the same cycle.
  assign in_ready_w    = tx_en && (level_q < FifoFull);
  assign push          = wr.in_valid && in_ready_w;
  assign fifo_empty    = (level_q == '0);
  assign wr.in_ready   = in_ready_w;
  assign wr.fifo_level = level_q;

  // Word boundary: the strobe that consumes the last preamble or last data symbol.
  assign at_last_sym   = (bit_idx_q == '0) && (!mode_q || half_q);
  assign word_end      = tx_en && bit_en &&
                         (((state_q == StPreamble) && (pre_cnt_q == PreLast)) ||
                          ((state_q == StActive) && at_last_sym));
  assign end_to_idle   = word_end && (state_q == StActive) && tx_idle;
  assign underflow_evt = word_end && !end_to_idle && !tx_data_sel && fifo_empty;
  assign load          = word_end && !end_to_idle && !underflow_evt;
  assign pop           = load && !tx_data_sel;
  assign err_cnt_inc   = {1'b0, err_cnt_q} + 9'd1;
  assign go_error      = (err_cnt_inc >= 9'(ERR_LIMIT));
  assign idx_m1        = bit_idx_q - IdxW'(1);
  assign next_word     = tx_data_sel ? prbs_word : mem_q[rd_ptr_q];

  // PRBS7 word generation, MSB first, one LFSR step per data bit.
  always_comb begin
    prbs_lfsr = lfsr_q;
    prbs_word = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      prbs_word[i] = prbs_lfsr[6];
      prbs_lfsr    = {prbs_lfsr[5:0], prbs_lfsr[6] ^ prbs_lfsr[5]};
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk_240m_tx) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr.in_data;
    end
  end

  // FIFO pointers and occupancy; flushed while the engine is disabled.
  always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
    if (!rst_n_240m_tx) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (!tx_en) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  // LFSR reseeds while disabled and advances one word per PRBS word load.
  always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
    if (!rst_n_240m_tx) begin
      lfsr_q <= LfsrSeed;
    end else if (!tx_en) begin
      lfsr_q <= LfsrSeed;
    end else if (load && tx_data_sel) begin
      lfsr_q <= prbs_lfsr;
    end
  end

  // Saturating underflow counter, cleared while disabled.
  always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
    if (!rst_n_240m_tx) begin
      err_cnt_q <= '0;
    end else if (!tx_en) begin
      err_cnt_q <= '0;
    end else if (underflow_evt && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_inc[7:0];
    end
  end

  // Sticky status: a set event wins over a coincident clear; survives disable.
  always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
    if (!rst_n_240m_tx) begin
      tx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      if (wr.in_valid && !in_ready_w && tx_en) tx_overflow <= 1'b1;
      else if (clr_sticky)                     tx_overflow <= 1'b0;
      if (underflow_evt)                       tx_underflow <= 1'b1;
      else if (clr_sticky)                     tx_underflow <= 1'b0;
    end
  end

  // Main FSM with registered line and status outputs.
  always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
    if (!rst_n_240m_tx) begin
      state_q         <= StDisabled;
      tx_serial_data  <= 1'b0;
      tx_serial_valid <= 1'b0;
      tx_idle_pattern <= 1'b1;
      tx_active       <= 1'b0;
      tx_error        <= 1'b0;
      word_q          <= '0;
      bit_idx_q       <= '0;
      half_q          <= 1'b0;
      mode_q          <= 1'b0;
      pre_cnt_q       <= '0;
    end else if (!tx_en) begin
      // Any partial word is simply dropped.
      state_q         <= StDisabled;
      tx_serial_data  <= 1'b0;
      tx_serial_valid <= 1'b0;
      tx_idle_pattern <= 1'b1;
      tx_active       <= 1'b0;
      tx_error        <= 1'b0;
      half_q          <= 1'b0;
    end else if (word_end) begin
      if (load) begin
        state_q         <= StActive;
        word_q          <= next_word;
        bit_idx_q       <= IdxTop;
        half_q          <= 1'b0;
        mode_q          <= mode_manchester;
        tx_serial_data  <= next_word[DATA_W-1];
        tx_serial_valid <= 1'b1;
      end else begin
        state_q         <= (underflow_evt && go_error) ? StError : StIdle;
        tx_serial_data  <= 1'b0;
        tx_serial_valid <= 1'b0;
        tx_idle_pattern <= !(underflow_evt && go_error);
        tx_active       <= 1'b0;
        tx_error        <= underflow_evt && go_error;
      end
    end else begin
      unique case (state_q)
        StDisabled: begin
          state_q <= StIdle;
        end
        StIdle: begin
          if (bit_en && !tx_idle && (tx_data_sel || !fifo_empty)) begin
            state_q         <= StPreamble;
            tx_serial_data  <= 1'b1;
            tx_serial_valid <= 1'b1;
            tx_idle_pattern <= 1'b0;
            tx_active       <= 1'b1;
            pre_cnt_q       <= PreW'(1);
          end
        end
        StPreamble: begin
          if (bit_en) begin
            tx_serial_data <= !tx_serial_data;
            pre_cnt_q      <= pre_cnt_q + PreW'(1);
          end
        end
        StActive: begin
          if (bit_en) begin
            if (mode_q && !half_q) begin
              // Manchester second half is the complement of the bit.
              half_q         <= 1'b1;
              tx_serial_data <= !word_q[bit_idx_q];
            end else begin
              half_q         <= 1'b0;
              bit_idx_q      <= idx_m1;
              tx_serial_data <= word_q[idx_m1];
            end
          end
        end
        StError: begin
          state_q <= StError;
        end
        default: begin
          state_q <= StDisabled;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdesphy_tx_serial_engine.sv
// Directed self-checking bench for serdesphy_tx_serial_engine (default parameters).
module tb_serdesphy_tx_serial_engine;

  logic clk_240m_tx = 1'b0;
  logic rst_n_240m_tx = 1'b0;
  logic tx_en, bit_en, tx_idle, tx_data_sel, mode_manchester, clr_sticky;
  logic tx_serial_data, tx_serial_valid, tx_idle_pattern, tx_active;
  logic tx_overflow, tx_underflow, tx_error;

  int checks = 0;
  int failures = 0;

  logic [23:0] vec_d, vec_v, vec_a, vec_b;
  logic [7:0]  fill_words [4];

  serdesphy_tx_serial_engine_if #(.DATA_W(8), .FIFO_DEPTH(4)) wr_if ();

  serdesphy_tx_serial_engine #(
    .DATA_W      (8),
    .FIFO_DEPTH  (4),
    .PREAMBLE_LEN(8),
    .ERR_LIMIT   (7)
  ) dut (
    .clk_240m_tx    (clk_240m_tx),
    .rst_n_240m_tx  (rst_n_240m_tx),
    .tx_en          (tx_en),
    .bit_en         (bit_en),
    .tx_idle        (tx_idle),
    .tx_data_sel    (tx_data_sel),
    .mode_manchester(mode_manchester),
    .clr_sticky     (clr_sticky),
    .wr             (wr_if.slave),
    .tx_serial_data (tx_serial_data),
    .tx_serial_valid(tx_serial_valid),
    .tx_idle_pattern(tx_idle_pattern),
    .tx_active      (tx_active),
    .tx_overflow    (tx_overflow),
    .tx_underflow   (tx_underflow),
    .tx_error       (tx_error)
  );

  always #5 clk_240m_tx = ~clk_240m_tx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample 1 time unit after the active edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk_240m_tx);
    #1;
  endtask

  // One single-word NRZ burst from the FIFO: 8 preamble + 8 data strobes, then boundary.
  task automatic burst(input logic [7:0] w);
    wr_if.in_data  = w;
    wr_if.in_valid = 1'b1;
    tick();
    wr_if.in_valid = 1'b0;
    bit_en = 1'b1;
    repeat (17) tick();
    bit_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    tx_en = 0; bit_en = 0; tx_idle = 0; tx_data_sel = 0; mode_manchester = 0; clr_sticky = 0;
    wr_if.in_data = '0; wr_if.in_valid = 0;
    fill_words[0] = 8'hF0; fill_words[1] = 8'h3C; fill_words[2] = 8'h81; fill_words[3] = 8'h7E;

    // Reset state
    #12;
    check("rst_outs", {tx_serial_data, tx_serial_valid, tx_idle_pattern, tx_active,
                       tx_overflow, tx_underflow, tx_error}, 7'b0010000);
    check("rst_level", wr_if.fifo_level, 0);
    check("rst_ready", wr_if.in_ready, 0);
    rst_n_240m_tx = 1'b1;
    tick();
    tx_en = 1'b1;
    tick();
    check("idle_outs", {tx_serial_data, tx_serial_valid, tx_idle_pattern}, 3'b001);
    check("idle_ready", wr_if.in_ready, 1);
    check("idle_level", wr_if.fifo_level, 0);

    // Manchester 8'hA5 burst, bit_en constant
    mode_manchester = 1'b1;
    wr_if.in_data = 8'hA5;
    wr_if.in_valid = 1'b1;
    tick();
    wr_if.in_valid = 1'b0;
    check("man_level1", wr_if.fifo_level, 1);
    bit_en = 1'b1;
    vec_d = '0; vec_v = '0;
    for (int i = 0; i < 24; i++) begin
      tick();
      vec_d = {vec_d[22:0], tx_serial_data};
      vec_v = {vec_v[22:0], tx_serial_valid};
      if (i == 12) check("man_active", tx_active, 1);
    end
    check("man_syms", vec_d, 24'hAA9966);
    check("man_valid", vec_v, 24'hFFFFFF);
    check("man_level0", wr_if.fifo_level, 0);
    tick();
    bit_en = 1'b0;
    check("man_end", {tx_serial_valid, tx_idle_pattern, tx_active}, 3'b010);
    check("man_udf", tx_underflow, 1);

    // PRBS7 NRZ, strobe every 3rd cycle, tx_idle raised mid second word
    mode_manchester = 1'b0;
    tx_data_sel = 1'b1;
    vec_a = '0; vec_b = '0;
    for (int s = 0; s < 25; s++) begin
      if (s == 20) tx_idle = 1'b1;
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
      if (s < 24) vec_a = {vec_a[22:0], tx_serial_data};
      tick();
      tick();
      if (s < 24) vec_b = {vec_b[22:0], tx_serial_data};
    end
    check("prbs_syms", vec_a, 24'hAAFE04);
    check("prbs_hold", vec_b, 24'hAAFE04);
    check("prbs_idle", {tx_serial_valid, tx_idle_pattern, tx_active}, 3'b010);
    tx_idle = 1'b0;
    tx_data_sel = 1'b0;

    // Sticky clear, FIFO fill and overflow
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("clr_both", {tx_overflow, tx_underflow}, 2'b00);
    wr_if.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_if.in_data = fill_words[i];
      tick();
    end
    check("full_ready", wr_if.in_ready, 0);
    check("full_ovf0", tx_overflow, 0);
    wr_if.in_data = 8'hFF;
    tick();
    wr_if.in_valid = 1'b0;
    check("full_level", wr_if.fifo_level, 4);
    check("ovf_set", tx_overflow, 1);
    clr_sticky = 1'b1;
    tick();
    check("ovf_clr", tx_overflow, 0);
    wr_if.in_valid = 1'b1;
    tick();
    check("ovf_set_wins", tx_overflow, 1);
    clr_sticky = 1'b0;
    wr_if.in_valid = 1'b0;

    // NRZ from full FIFO (first word 8'hF0), tx_en dropped mid-word
    bit_en = 1'b1;
    repeat (9) tick();
    check("drop_sym0", tx_serial_data, 1);
    check("drop_level3", wr_if.fifo_level, 3);
    repeat (4) tick();
    check("drop_sym4", tx_serial_data, 0);
    tx_en = 1'b0;
    tick();
    bit_en = 1'b0;
    check("drop_line", {tx_serial_data, tx_serial_valid, tx_active, tx_idle_pattern}, 4'b0001);
    check("drop_level", wr_if.fifo_level, 0);
    check("drop_ready", wr_if.in_ready, 0);
    check("drop_sticky", tx_overflow, 1);

    // Seven underflowing bursts reach ERROR
    tx_en = 1'b1;
    tick();
    for (int n = 0; n < 7; n++) begin
      burst(8'h5A + 8'(n));
      check("err_flag", tx_error, (n == 6));
      check("err_valid", tx_serial_valid, 0);
    end
    check("err_idlepat", tx_idle_pattern, 0);
    bit_en = 1'b1;
    repeat (3) tick();
    bit_en = 1'b0;
    check("err_holds", {tx_error, tx_serial_valid, tx_active}, 3'b100);
    tx_en = 1'b0;
    tick();
    check("err_exit", {tx_error, tx_idle_pattern}, 2'b01);
    tx_en = 1'b1;
    tick();
    burst(8'hC3);
    check("cnt_cleared", {tx_error, tx_idle_pattern, tx_serial_valid}, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
